// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request bus and register-file write-port signals.
// Request side and file side are grouped here because one arbiter owns them all.
interface regfile_wb_arbiter_if #(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 3
);
  logic                      en;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      rf_we;
  logic [ADDR_W-1:0]         rf_waddr;
  logic [DATA_W-1:0]         rf_wdata;
  logic [1:0]                grant_id;
  logic                      busy;
  logic [(2**ADDR_W)-1:0]    pending_mask;
  logic                      wr_done;

  modport master (
    output en, req_valid, req_addr, req_data,
    input  req_ready, rf_we, rf_waddr, rf_wdata, grant_id, busy, pending_mask, wr_done
  );

  modport slave (
    input  en, req_valid, req_addr, req_data,
    output req_ready, rf_we, rf_waddr, rf_wdata, grant_id, busy, pending_mask, wr_done
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter for the single register-file write port: accept, issue rf_we for
// one cycle, then hold address/data while the file commits; publishes in-flight target.
module regfile_wb_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  regfile_wb_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, COMMIT} state_t;

  state_t            state, state_nxt;
  logic [1:0]        ptr;
  logic [1:0]        grant_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [1:0]        winner;
  logic              any_valid;
  logic              accept;

  // First valid requester strictly after the last winner, wrapping.
  always_comb begin
    int idx;
    idx       = 0;
    winner    = '0;
    any_valid = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!any_valid && bus.req_valid[idx]) begin
        any_valid = 1'b1;
        winner    = 2'(idx);
      end
    end
  end

  // Grants only open in IDLE or COMMIT so the port sees at most one write per two cycles.
  assign accept = !reset && bus.en && any_valid && (state == IDLE || state == COMMIT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr     <= 2'(NUM_REQ - 1);
      grant_q <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      ptr     <= winner;
      grant_q <= winner;
      waddr_q <= bus.req_addr[int'(winner)*ADDR_W +: ADDR_W];
      wdata_q <= bus.req_data[int'(winner)*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = accept ? ISSUE : IDLE;
      ISSUE:   state_nxt = COMMIT;
      COMMIT:  state_nxt = accept ? ISSUE : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready    = '0;
    bus.rf_we        = (state == ISSUE);
    bus.wr_done      = (state == COMMIT);
    bus.busy         = (state == ISSUE) || (state == COMMIT);
    bus.pending_mask = '0;
    for (int i = 0; i < NUM_REQ; i++)
      bus.req_ready[i] = accept && (winner == 2'(i));
    // Bit tracks the latched target; a same-register back-to-back grant keeps it set.
    if (bus.busy) bus.pending_mask[waddr_q] = 1'b1;
  end

  assign bus.rf_waddr = waddr_q;
  assign bus.rf_wdata = wdata_q;
  assign bus.grant_id = grant_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter with a one-cycle-delayed register-file model.
module tb_regfile_wb_arbiter;
  localparam int NUM_REQ = 3;
  localparam int DATA_W  = 8;
  localparam int ADDR_W  = 3;

  logic clk;
  logic reset;
  int   n_cmp = 0;
  int   n_mis = 0;

  regfile_wb_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  regfile_wb_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // File model: commits the cycle after rf_we; reset abandons anything in flight.
  logic              we_d;
  logic [DATA_W-1:0] mem [2**ADDR_W];
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      we_d <= 1'b0;
      for (int r = 0; r < 2**ADDR_W; r++) mem[r] <= '0;
    end else begin
      we_d <= bus.rf_we;
      if (we_d) mem[bus.rf_waddr] <= bus.rf_wdata;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_req(input int i, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    bus.req_addr[i*ADDR_W +: ADDR_W] = a;
    bus.req_data[i*DATA_W +: DATA_W] = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    clk = 0; reset = 1;
    bus.en = 1; bus.req_valid = 3'b111; bus.req_addr = '0; bus.req_data = '0;

    // Reset state, with requests present
    tick(); #1;
    chk("rst_ready", 32'(bus.req_ready), 0);
    chk("rst_we",    32'(bus.rf_we), 0);
    chk("rst_done",  32'(bus.wr_done), 0);
    chk("rst_busy",  32'(bus.busy), 0);
    chk("rst_pmask", 32'(bus.pending_mask), 0);
    chk("rst_waddr", 32'(bus.rf_waddr), 0);
    chk("rst_wdata", 32'(bus.rf_wdata), 0);
    chk("rst_gid",   32'(bus.grant_id), 0);
    bus.req_valid = '0; bus.en = 0;
    tick(); reset = 0;

    // Single request: r5 <= -100
    tick();
    set_req(0, 3'd5, 8'h9C); bus.req_valid = 3'b001; bus.en = 1; #1;
    chk("t1_ready", 32'(bus.req_ready), 32'h1);
    chk("t1_busy0", 32'(bus.busy), 0);
    tick(); bus.req_valid = '0; #1;
    chk("t1_we",    32'(bus.rf_we), 1);
    chk("t1_waddr", 32'(bus.rf_waddr), 5);
    chk("t1_wdata", 32'(bus.rf_wdata), 32'h9C);
    chk("t1_gid",   32'(bus.grant_id), 0);
    chk("t1_pmask", 32'(bus.pending_mask), 32'h20);
    chk("t1_rdy_issue", 32'(bus.req_ready), 0);
    tick(); #1;
    chk("t1_we_c",  32'(bus.rf_we), 0);
    chk("t1_done",  32'(bus.wr_done), 1);
    chk("t1_waddr_c", 32'(bus.rf_waddr), 5);
    chk("t1_pmask_c", 32'(bus.pending_mask), 32'h20);
    tick(); #1;
    chk("t1_idle_busy",  32'(bus.busy), 0);
    chk("t1_idle_pmask", 32'(bus.pending_mask), 0);
    chk("t1_idle_done",  32'(bus.wr_done), 0);
    chk("t1_idle_waddr", 32'(bus.rf_waddr), 5);
    chk("t1_idle_wdata", 32'(bus.rf_wdata), 32'h9C);
    chk("t1_mem5", 32'(mem[5]), 32'h9C);

    // Round robin from reset, all valid continuously
    reset = 1; #1;
    chk("t2_rst_busy", 32'(bus.busy), 0);
    tick(); reset = 0;
    set_req(0, 3'd1, 8'h11); set_req(1, 3'd2, 8'h22); set_req(2, 3'd3, 8'h33);
    bus.req_valid = 3'b111; #1;
    for (int g = 0; g < 6; g++) begin
      chk("t2_ready", 32'(bus.req_ready), 32'(1 << (g % 3)));
      tick(); #1;
      chk("t2_we",    32'(bus.rf_we), 1);
      chk("t2_gid",   32'(bus.grant_id), 32'(g % 3));
      chk("t2_wdata", 32'(bus.rf_wdata), 32'((g % 3 + 1) * 'h11));
      tick();
      if (g == 5) bus.req_valid = '0;
      #1;
      chk("t2_done", 32'(bus.wr_done), 1);
    end
    chk("t2_ready_end", 32'(bus.req_ready), 0);
    tick(); #1;
    chk("t2_busy", 32'(bus.busy), 0);
    chk("t2_mem1", 32'(mem[1]), 32'h11);
    chk("t2_mem2", 32'(mem[2]), 32'h22);
    chk("t2_mem3", 32'(mem[3]), 32'h33);

    // Back-to-back writes to r2 from req1 then req2
    set_req(1, 3'd2, 8'h41); set_req(2, 3'd2, 8'h7F); bus.req_valid = 3'b110; #1;
    chk("t3_ready1", 32'(bus.req_ready), 32'h2);
    tick(); bus.req_valid = 3'b100; #1;
    chk("t3_gid1",   32'(bus.grant_id), 1);
    chk("t3_wdata1", 32'(bus.rf_wdata), 32'h41);
    chk("t3_pm1",    32'(bus.pending_mask), 32'h04);
    tick(); #1;
    chk("t3_ready2", 32'(bus.req_ready), 32'h4);
    chk("t3_pm2",    32'(bus.pending_mask), 32'h04);
    tick(); bus.req_valid = '0; #1;
    chk("t3_gid2",   32'(bus.grant_id), 2);
    chk("t3_wdata2", 32'(bus.rf_wdata), 32'h7F);
    chk("t3_pm3",    32'(bus.pending_mask), 32'h04);
    tick(); #1;
    chk("t3_pm4",    32'(bus.pending_mask), 32'h04);
    tick(); #1;
    chk("t3_pm_idle", 32'(bus.pending_mask), 0);
    chk("t3_mem2",    32'(mem[2]), 32'h7F);

    // en=0 blocks grants; en=1 grants
    bus.en = 0; set_req(0, 3'd6, 8'h5A); bus.req_valid = 3'b001; #1;
    chk("t4_ready_off", 32'(bus.req_ready), 0);
    tick(); #1;
    chk("t4_we_off",   32'(bus.rf_we), 0);
    chk("t4_busy_off", 32'(bus.busy), 0);
    tick(); #1;
    chk("t4_ready_off2", 32'(bus.req_ready), 0);
    bus.en = 1; #1;
    chk("t4_ready_on", 32'(bus.req_ready), 32'h1);
    tick(); bus.req_valid = '0; #1;
    chk("t4_we_on",  32'(bus.rf_we), 1);
    chk("t4_waddr",  32'(bus.rf_waddr), 6);
    tick(); #1;
    chk("t4_done", 32'(bus.wr_done), 1);
    tick();

    // en drops during ISSUE: in-flight write completes, no new grant
    set_req(1, 3'd1, 8'h66); bus.req_valid = 3'b010; #1;
    chk("t4b_ready", 32'(bus.req_ready), 32'h2);
    tick(); bus.en = 0; bus.req_valid = 3'b100; #1;
    chk("t4b_we", 32'(bus.rf_we), 1);
    tick(); #1;
    chk("t4b_ready_c", 32'(bus.req_ready), 0);
    chk("t4b_done",    32'(bus.wr_done), 1);
    tick(); #1;
    chk("t4b_busy", 32'(bus.busy), 0);
    chk("t4b_we_i", 32'(bus.rf_we), 0);
    chk("t4b_mem1", 32'(mem[1]), 32'h66);

    // Reset during ISSUE; RR restarts at req0
    bus.en = 1; bus.req_valid = 3'b111; #1;
    chk("t5_ready", 32'(bus.req_ready), 32'h4);
    tick(); #1;
    chk("t5_we", 32'(bus.rf_we), 1);
    reset = 1; #1;
    chk("t5_we_rst",   32'(bus.rf_we), 0);
    chk("t5_busy_rst", 32'(bus.busy), 0);
    chk("t5_pm_rst",   32'(bus.pending_mask), 0);
    tick(); #1;
    chk("t5_no_done", 32'(bus.wr_done), 0);
    reset = 0; #1;
    chk("t5_rr_restart", 32'(bus.req_ready), 32'h1);
    bus.req_valid = '0; #1;

    // req1 held 5 cycles while req0 owns the port and en is low
    tick();
    set_req(0, 3'd3, 8'h10); bus.req_valid = 3'b001; #1;
    chk("t6_ready0", 32'(bus.req_ready), 32'h1);
    tick(); set_req(1, 3'd4, 8'hC3); bus.req_valid = 3'b010; bus.en = 0; #1;
    chk("t6_gid0", 32'(bus.grant_id), 0);
    tick(); #1;
    chk("t6_wait_c", 32'(bus.req_ready), 0);
    tick(); tick(); tick(); #1;
    chk("t6_wait_i", 32'(bus.req_ready), 0);
    bus.en = 1; #1;
    chk("t6_ready1", 32'(bus.req_ready), 32'h2);
    tick(); bus.req_valid = '0; #1;
    chk("t6_wdata", 32'(bus.rf_wdata), 32'hC3);
    chk("t6_waddr", 32'(bus.rf_waddr), 4);
    chk("t6_gid1",  32'(bus.grant_id), 1);
    tick(); #1;
    chk("t6_done", 32'(bus.wr_done), 1);
    tick(); #1;
    chk("t6_mem3", 32'(mem[3]), 32'h10);
    chk("t6_mem4", 32'(mem[4]), 32'hC3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
